// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, start-glitch rejection,
// optional odd/even parity, framing/parity flags qualified by a one-cycle out_valid strobe.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pmis_q, pmis_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 bit_end;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data, input logic pbit);
    if (PARITY == 0) begin
      return 1'b0;
    end
    return ((^data) ^ pbit) != PAR_ODD;
  endfunction

  assign rx_s    = sync_q[1];
  assign bit_end = (cnt_q == CNT_LAST);

  // Control state, synchroniser and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pmis_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], RXD};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pmis_q  <= pmis_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  // Shift register holds only data and needs no reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pmis_d  = pmis_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is gone by mid-bit is line noise
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          pmis_d  = parity_mismatch(shift_q, rx_s);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          out_d   = shift_q;
          valid_d = 1'b1;
          ferr_d  = ~rx_s;
          perr_d  = (PARITY != 0) ? pmis_q : 1'b0;
          // Leaving at mid-stop lets a back-to-back start edge be caught
          state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out        = out_q;
  assign out_valid  = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one 8N1 receiver and a 7-bit even/odd pair sharing one serial line.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } rec_t;

  typedef struct {
    int         line;
    logic [8:0] data;
    logic       pbit;
    logic       stopb;
    logic [8:0] exp_out;
    logic       exp_fe;
    logic       exp_pe_e;
    logic       exp_pe_o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd0;
  logic       rxdp;
  logic [7:0] out0;
  logic [6:0] oute;
  logic [6:0] outo;
  logic       ov0, ove, ovo;
  logic       fe0, fee, feo;
  logic       pe0, pee, peo;
  logic       busy0, busye, busyo;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  rec_t q0[$];
  rec_t qe[$];
  rec_t qo[$];
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .RXD(rxd0), .out(out0), .out_valid(ov0),
    .frame_err(fe0), .parity_err(pe0), .busy(busy0)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) ue (
    .clk(clk), .rst(rst), .RXD(rxdp), .out(oute), .out_valid(ove),
    .frame_err(fee), .parity_err(pee), .busy(busye)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1)) uo (
    .clk(clk), .rst(rst), .RXD(rxdp), .out(outo), .out_valid(ovo),
    .frame_err(feo), .parity_err(peo), .busy(busyo)
  );

  always @(negedge clk) begin
    if (ov0 === 1'b1) q0.push_back('{data: {1'b0, out0}, fe: fe0, pe: pe0, cyc: cyc});
    if (ove === 1'b1) qe.push_back('{data: {2'b0, oute}, fe: fee, pe: pee, cyc: cyc});
    if (ovo === 1'b1) qo.push_back('{data: {2'b0, outo}, fe: feo, pe: peo, cyc: cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int act, input int exp);
    n_chk++;
    if (act < exp - 1 || act > exp + 1) begin
      n_fail++;
      $display("FAIL %s: latency %0d cycles, expected %0d +/-1", name, act, exp);
    end
  endtask

  task automatic hold();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic set_line(input int line, input logic v);
    if (line == 0) rxd0 = v;
    else rxdp = v;
  endtask

  task automatic send_frame(input int line, input logic [8:0] data, input int nbits,
                            input bit pen, input logic pbit, input logic stopb, output int t_fall);
    set_line(line, 1'b0);
    t_fall = cyc;
    hold();
    for (int i = 0; i < nbits; i++) begin
      set_line(line, data[i]);
      hold();
    end
    if (pen) begin
      set_line(line, pbit);
      hold();
    end
    set_line(line, stopb);
    hold();
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return qe.size();
      default: return qo.size();
    endcase
  endfunction

  task automatic pop_rec(input int which, input string name, output rec_t r, output bit ok);
    int i;
    i  = 0;
    r  = '{data: '0, fe: 1'b0, pe: 1'b0, cyc: 0};
    ok = 1'b0;
    while (qsize(which) == 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    n_chk++;
    if (qsize(which) == 0) begin
      n_fail++;
      $display("FAIL %s: no out_valid strobe, got 0 strobes within 60 cycles, expected 1", name);
    end else begin
      ok = 1'b1;
      case (which)
        0:       r = q0.pop_front();
        1:       r = qe.pop_front();
        default: r = qo.pop_front();
      endcase
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   tf;
    int   nb;
    int   pen;
    int   exp_lat;
    rec_t r;
    bit   ok;
    nb      = (v.line == 0) ? 8 : 7;
    pen     = (v.line == 0) ? 0 : 1;
    exp_lat = 2 + HALF + (nb + pen + 1) * CPB + 1;
    repeat (8) @(negedge clk);
    send_frame(v.line, v.data, nb, (v.line != 0), v.pbit, v.stopb, tf);
    if (v.line == 0) begin
      pop_rec(0, {tag, " strobe"}, r, ok);
      if (ok) begin
        chk({tag, " out"}, r.data, v.exp_out);
        chk({tag, " frame_err"}, r.fe, v.exp_fe);
        chk({tag, " parity_err"}, r.pe, v.exp_pe_e);
        chk_lat({tag, " latency"}, r.cyc - tf, exp_lat);
      end
      repeat (4) @(negedge clk);
      chk({tag, " busy after strobe"}, busy0, 1'b0);
      chk({tag, " extra strobes"}, q0.size(), 0);
    end else begin
      pop_rec(1, {tag, " even strobe"}, r, ok);
      if (ok) begin
        chk({tag, " even out"}, r.data, v.exp_out);
        chk({tag, " even frame_err"}, r.fe, v.exp_fe);
        chk({tag, " even parity_err"}, r.pe, v.exp_pe_e);
        chk_lat({tag, " even latency"}, r.cyc - tf, exp_lat);
      end
      pop_rec(2, {tag, " odd strobe"}, r, ok);
      if (ok) begin
        chk({tag, " odd out"}, r.data, v.exp_out);
        chk({tag, " odd frame_err"}, r.fe, v.exp_fe);
        chk({tag, " odd parity_err"}, r.pe, v.exp_pe_o);
      end
      repeat (4) @(negedge clk);
      chk({tag, " busy after strobe"}, {busye, busyo}, 2'b00);
      chk({tag, " extra strobes"}, qe.size() + qo.size(), 0);
    end
  endtask

  initial begin
    int   tf;
    rec_t r;
    bit   ok;
    logic [8:0] b2b [3];
    vec_t v;

    //            line data    pbit  stop  exp_out fe    pe_e  pe_o
    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h00F, 1'b0, 1'b1, 9'h00F, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1, 9'h041, 1'b0, 1'b1, 9'h041, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1, 9'h041, 1'b1, 1'b1, 9'h041, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 9'h02A, 1'b1, 1'b1, 9'h02A, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1, 9'h07F, 1'b0, 1'b1, 9'h07F, 1'b0, 1'b1, 1'b0};
    b2b[0] = 9'h000;
    b2b[1] = 9'h0FF;
    b2b[2] = 9'h03C;

    rst  = 1'b1;
    rxd0 = 1'b1;
    rxdp = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset out", out0, 8'h00);
    chk("reset out_valid", ov0, 1'b0);
    chk("reset frame_err", fe0, 1'b0);
    chk("reset parity_err", {pe0, pee, peo}, 3'b000);
    chk("reset busy", {busy0, busye, busyo}, 3'b000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Three frames with no idle between stop and next start
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      send_frame(0, b2b[k], 8, 1'b0, 1'b0, 1'b1, tf);
    end
    for (int k = 0; k < 3; k++) begin
      pop_rec(0, $sformatf("b2b%0d strobe", k), r, ok);
      if (ok) begin
        chk($sformatf("b2b%0d out", k), r.data, b2b[k]);
        chk($sformatf("b2b%0d errors", k), {r.fe, r.pe}, 2'b00);
      end
    end
    repeat (4) @(negedge clk);
    chk("b2b extra strobes", q0.size(), 0);

    // Short low pulse on an idle line
    rxd0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch busy during pulse", busy0, 1'b1);
    rxd0 = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch busy after", busy0, 1'b0);
    chk("glitch strobes", q0.size(), 0);
    v = '{0, 9'h055, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0};
    run_vec(v, "after glitch");

    // Stop bit low followed by a held break
    repeat (8) @(negedge clk);
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b0, tf);
    repeat (40) @(negedge clk);
    chk("break strobe count", q0.size(), 1);
    pop_rec(0, "break strobe", r, ok);
    if (ok) begin
      chk("break out", r.data, 9'h081);
      chk("break frame_err", r.fe, 1'b1);
      chk("break parity_err", r.pe, 1'b0);
    end
    chk("break busy while low", busy0, 1'b1);
    repeat (40) @(negedge clk);
    chk("break no further strobe", q0.size(), 0);
    rxd0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("break busy after release", busy0, 1'b0);
    chk("break strobes after release", q0.size(), 0);
    v = '{0, 9'h012, 1'b0, 1'b1, 9'h012, 1'b0, 1'b0, 1'b0};
    run_vec(v, "after break");

    // Reset pulse in the middle of data bit 4 of 0xC3
    repeat (8) @(negedge clk);
    rxd0 = 1'b0;
    hold();
    for (int i = 0; i < 4; i++) begin
      rxd0 = b2b[2][0] ^ b2b[2][0] ^ ((8'hC3 >> i) & 8'h01) != 8'h00;
      hold();
    end
    rxd0 = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("midframe busy before rst", busy0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    rxd0 = 1'b1;
    repeat (40) @(negedge clk);
    chk("midframe strobes", q0.size(), 0);
    chk("midframe out", out0, 8'h00);
    chk("midframe flags", {ov0, fe0, pe0}, 3'b000);
    chk("midframe busy", busy0, 1'b0);
    v = '{0, 9'h07E, 1'b0, 1'b1, 9'h07E, 1'b0, 1'b0, 1'b0};
    run_vec(v, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, 8N1/8E1/8O1-class, for the host-to-FPGA command path of the scope.
- Generalises the fixed 8N1 receiver:
  - configurable baud divisor, data width and parity mode;
  - input synchroniser and mid-bit sampling;
  - start-bit glitch rejection;
  - framing and parity error flags;
  - a one-cycle valid strobe instead of a level.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range ≥ 4.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- RXD  in  1  asynchronous serial line; idles high.
- out  out  DATA_BITS  last received data word.
- out_valid  out  1  one-cycle strobe: a frame completed and out/flags were updated this cycle.
- frame_err  out  1  stop bit of the last frame sampled 0; updated with out_valid.
- parity_err  out  1  parity mismatch on the last frame; always 0 when PARITY = 0; updated with out_valid.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - Synchronous: rst is sampled on the rising edge of clk.
  - out = 0, out_valid = 0, frame_err = 0, parity_err = 0, busy = 0.
  - Synchroniser flops are set to 1 (idle line); FSM goes to IDLE; counters clear.
  - rst mid-frame aborts the frame with no out_valid. The receiver re-arms on the next falling edge seen after reset.
- Synchroniser: RXD passes through 2 flops to give rx_s, adding 2 cycles of latency. All decisions use rx_s only.
- Counters:
  - Bit counter cnt is $clog2(CLKS_PER_BIT) bits wide.
  - Bit index is $clog2(DATA_BITS+1) bits wide.
  - HALF = CLKS_PER_BIT/2, using integer division.
- IDLE:
  - rx_s == 0 → START, cnt = 0.
- START:
  - cnt increments each cycle.
  - At cnt == HALF-1, sample rx_s.
  - If rx_s == 1: glitch → IDLE, no output.
  - If rx_s == 0: → DATA, cnt = 0, index = 0.
- DATA:
  - At cnt == CLKS_PER_BIT-1, sample rx_s into shift[index] (LSB first), index++, cnt = 0.
  - After DATA_BITS samples: → PARITY if PARITY != 0, else → STOP.
- PARITY:
  - At cnt == CLKS_PER_BIT-1, sample the parity bit.
  - Mismatch if XOR(data, pbit) != 1 for odd, or != 0 for even.
  - → STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1, sample the stop bit.
  - On the next cycle: out <= shift, out_valid = 1 for exactly 1 cycle, frame_err <= ~stop, parity_err <= mismatch.
  - stop == 1 → IDLE, so a back-to-back start bit is detected from mid-stop-bit onward.
  - stop == 0 → WAIT_HIGH.
- WAIT_HIGH (break / framing error):
  - Stay until rx_s == 1, then → IDLE.
  - A line held low produces exactly one out_valid with frame_err = 1.
- Hold rules:
  - out, frame_err and parity_err hold their values between strobes.
  - out_valid is asserted for every completed frame, errors included; the error flags qualify it.
  - There is no ready/backpressure; the consumer must capture on the strobe.
- Latency:
  - out_valid rises 2 + HALF + (DATA_BITS + P + 1)·CLKS_PER_BIT + 1 cycles after the RXD falling edge, ±1 cycle.
  - P = 1 if PARITY != 0, else 0.
- Baud tolerance: sampling is mid-bit with timing re-anchored at the start edge per frame. Tolerance is ±4 % combined.

Test Plan:
- CLKS_PER_BIT=16, DATA_BITS=8, PARITY=0; send 0xA5 as 8N1 → one out_valid, out=0xA5, frame_err=0, parity_err=0, busy low after the strobe. Latency matches the formula within ±1.
- Same config; send 0x00, 0xFF, 0x3C back-to-back with 1 stop bit and no idle gap → three strobes with out = 0x00, 0xFF, 0x3C in order, no errors.
- Same config; pulse RXD low for 5 cycles (< HALF) → no out_valid; busy returns to 0; a following 0x55 frame is received correctly.
- Same config; send 0x81 with the stop bit forced 0, then hold RXD low 40 cycles → exactly one strobe with out=0x81, frame_err=1. No further strobe until RXD returns high; the next 0x12 frame is received cleanly.
- PARITY=2 (even), DATA_BITS=7: send 0x41 with correct parity 0 → parity_err=0. Send 0x41 with parity 1 → out=0x41, parity_err=1. Repeat with PARITY=1: flags invert.
- Assert rst for 1 cycle during data bit 4 of a 0xC3 frame → no strobe, all outputs 0. A subsequent 0x7E frame yields out=0x7E with no errors.
